// File: rtl/uex_mem_responder_if.sv
// Request/response bundle between the uex transactor fabric and the memory responder.
// The master drives requests and rsp_ready; the slave (memory model) answers.
interface uex_mem_responder_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_write;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic [DATA_WIDTH/8-1:0] req_wstrb;
    logic [3:0]              wait_cycles;

    logic                    rsp_valid;
    logic                    rsp_ready;
    logic                    rsp_write;
    logic                    rsp_error;
    logic [DATA_WIDTH-1:0]   rsp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb, wait_cycles, rsp_ready,
        input  req_ready, rsp_valid, rsp_write, rsp_error, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb, wait_cycles, rsp_ready,
        output req_ready, rsp_valid, rsp_write, rsp_error, rsp_rdata
    );
endinterface

// File: rtl/uex_mem_responder.sv
// Word RAM memory model: one request at a time, response pushed 1+wait_cycles edges after accept.
// Requests stall (req_ready=0) while busy or while the response FIFO is full; responses hold until popped.
module uex_mem_responder #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_BYTES  = 4096,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    uex_mem_responder_if.slave     bus,
    output logic                   busy
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF   = $clog2(BYTES);
    localparam int WORDS = MEM_BYTES / BYTES;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH+1)'(MEM_BYTES);
    localparam logic [PTR_W:0]      FIFO_FULL = (PTR_W+1)'(RSP_DEPTH);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    typedef struct packed {
        logic                  write;
        logic                  error;
        logic [DATA_WIDTH-1:0] rdata;
    } rsp_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  write_q, write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [BYTES-1:0]      wstrb_q, wstrb_d;

    logic [DATA_WIDTH-1:0] mem [WORDS];

    rsp_t                  fifo_q [RSP_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]        count_q;

    logic                  req_rdy;
    logic                  push;
    logic                  pop;
    logic                  in_range;
    logic [IDX_W-1:0]      word_idx;
    rsp_t                  push_entry;
    rsp_t                  head;

    assign in_range = {1'b0, addr_q} < MEM_LIMIT;
    assign word_idx = addr_q[OFF +: IDX_W];

    always_comb begin
        push_entry       = '0;
        push_entry.write = write_q;
        push_entry.error = !in_range;
        if (!write_q && in_range) begin
            push_entry.rdata = mem[word_idx];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        push    = 1'b0;
        req_rdy = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Gated by reset_n so the channel is closed for the whole reset window.
                req_rdy = reset_n && (count_q < FIFO_FULL);
                if (bus.req_valid && req_rdy) begin
                    write_d = bus.req_write;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    wstrb_d = bus.req_wstrb;
                    cnt_d   = bus.wait_cycles;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    push    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
        end
    end

    // RAM has no reset so its contents survive a reset pulse.
    always_ff @(posedge clock) begin
        if (push && write_q && in_range) begin
            for (int i = 0; i < BYTES; i++) begin
                if (wstrb_q[i]) begin
                    mem[word_idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign pop = bus.rsp_valid && bus.rsp_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= push_entry;
                wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head          = fifo_q[rd_ptr_q];
    assign bus.rsp_valid = (count_q != '0);
    assign bus.rsp_write = bus.rsp_valid & head.write;
    assign bus.rsp_error = bus.rsp_valid & head.error;
    assign bus.rsp_rdata = bus.rsp_valid ? head.rdata : '0;
    assign bus.req_ready = req_rdy;
    assign busy          = (state_q != S_IDLE);
endmodule

// File: tb/tb_uex_mem_responder.sv
// Directed bench for uex_mem_responder: latency, byte strobes, range errors, backpressure, reset flush.
module tb_uex_mem_responder;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic busy;
    int   checks = 0;
    int   errors = 0;

    uex_mem_responder_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();

    uex_mem_responder #(
        .ADDR_WIDTH(16), .DATA_WIDTH(32), .MEM_BYTES(4096), .RSP_DEPTH(4)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus),
        .busy    (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic wr, input logic [15:0] addr, input logic [31:0] wd,
                        input logic [3:0] st, input logic [3:0] wt);
        int n;
        n = 0;
        bus.req_valid   = 1'b1;
        bus.req_write   = wr;
        bus.req_addr    = addr;
        bus.req_wdata   = wd;
        bus.req_wstrb   = st;
        bus.wait_cycles = wt;
        while (!bus.req_ready && n < 50) begin
            step();
            n++;
        end
        check("req_ready_before_accept", bus.req_ready, 1'b1);
        step();
        bus.req_valid = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic wr, input logic err, input logic [31:0] rd);
        int n;
        n = 0;
        while (!bus.rsp_valid && n < 50) begin
            step();
            n++;
        end
        check({tag, ".valid"}, bus.rsp_valid, 1'b1);
        check({tag, ".write"}, bus.rsp_write, wr);
        check({tag, ".error"}, bus.rsp_error, err);
        check({tag, ".rdata"}, bus.rsp_rdata, rd);
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        bus.req_valid   = 1'b0;
        bus.req_write   = 1'b0;
        bus.req_addr    = '0;
        bus.req_wdata   = '0;
        bus.req_wstrb   = '0;
        bus.wait_cycles = '0;
        bus.rsp_ready   = 1'b0;

        // Reset values
        repeat (3) step();
        check("rst.req_ready", bus.req_ready, 1'b0);
        check("rst.rsp_valid", bus.rsp_valid, 1'b0);
        check("rst.rsp_write", bus.rsp_write, 1'b0);
        check("rst.rsp_error", bus.rsp_error, 1'b0);
        check("rst.rsp_rdata", bus.rsp_rdata, 32'h0);
        check("rst.busy", busy, 1'b0);
        reset_n = 1'b1;
        #1;
        check("rel.req_ready", bus.req_ready, 1'b1);
        step();

        // Write then read, zero wait states
        send(1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 4'd0);
        check("w0.busy_E", busy, 1'b1);
        check("w0.req_ready_E", bus.req_ready, 1'b0);
        check("w0.rsp_valid_E", bus.rsp_valid, 1'b0);
        step();
        check("w0.rsp_valid_E1", bus.rsp_valid, 1'b1);
        check("w0.busy_E1", busy, 1'b0);
        pop_check("w0", 1'b1, 1'b0, 32'h0);
        check("w0.empty_after_pop", bus.rsp_valid, 1'b0);
        send(1'b0, 16'h0010, 32'h0, 4'h0, 4'd0);
        check("r0.rsp_valid_E", bus.rsp_valid, 1'b0);
        step();
        check("r0.rsp_valid_E1", bus.rsp_valid, 1'b1);
        pop_check("r0", 1'b0, 1'b0, 32'hDEADBEEF);

        // Byte strobes and ignored low address bits
        send(1'b1, 16'h0020, 32'h11223344, 4'hF, 4'd0);
        pop_check("w1", 1'b1, 1'b0, 32'h0);
        send(1'b1, 16'h0020, 32'hAABBCCDD, 4'h5, 4'd0);
        pop_check("w2", 1'b1, 1'b0, 32'h0);
        send(1'b0, 16'h0022, 32'h0, 4'h0, 4'd0);
        pop_check("r_strb", 1'b0, 1'b0, 32'h11BB33DD);
        send(1'b1, 16'h0020, 32'hFFFFFFFF, 4'h0, 4'd0);
        pop_check("w_nostrb", 1'b1, 1'b0, 32'h0);
        send(1'b0, 16'h0020, 32'h0, 4'hF, 4'd0);
        pop_check("r_nostrb", 1'b0, 1'b0, 32'h11BB33DD);

        // Address range
        send(1'b1, 16'h0FFC, 32'h01020304, 4'hF, 4'd0);
        pop_check("w_top", 1'b1, 1'b0, 32'h0);
        send(1'b1, 16'h0000, 32'h55AA55AA, 4'hF, 4'd0);
        pop_check("w_zero", 1'b1, 1'b0, 32'h0);
        send(1'b0, 16'h1000, 32'h0, 4'h0, 4'd0);
        pop_check("r_oor", 1'b0, 1'b1, 32'h0);
        send(1'b1, 16'h2000, 32'hCAFEF00D, 4'hF, 4'd0);
        pop_check("w_oor", 1'b1, 1'b1, 32'h0);
        send(1'b0, 16'h0FFC, 32'h0, 4'h0, 4'd0);
        pop_check("r_top", 1'b0, 1'b0, 32'h01020304);
        send(1'b0, 16'h0000, 32'h0, 4'h0, 4'd0);
        pop_check("r_zero_after_oor", 1'b0, 1'b0, 32'h55AA55AA);

        // Seven wait states
        send(1'b0, 16'h0010, 32'h0, 4'h0, 4'd7);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("wait7.busy_%0d", i), busy, 1'b1);
            check($sformatf("wait7.req_ready_%0d", i), bus.req_ready, 1'b0);
            check($sformatf("wait7.rsp_valid_%0d", i), bus.rsp_valid, 1'b0);
            step();
        end
        check("wait7.busy_end", busy, 1'b0);
        check("wait7.rsp_valid_end", bus.rsp_valid, 1'b1);
        pop_check("wait7", 1'b0, 1'b0, 32'hDEADBEEF);

        // Backpressure: fill the response FIFO
        send(1'b0, 16'h0010, 32'h0, 4'h0, 4'd0);
        send(1'b0, 16'h0020, 32'h0, 4'h0, 4'd0);
        send(1'b0, 16'h0FFC, 32'h0, 4'h0, 4'd0);
        send(1'b0, 16'h0000, 32'h0, 4'h0, 4'd0);
        step();
        bus.req_valid   = 1'b1;
        bus.req_write   = 1'b0;
        bus.req_addr    = 16'h1004;
        bus.wait_cycles = 4'd0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("full.req_ready_%0d", i), bus.req_ready, 1'b0);
            check($sformatf("full.head_%0d", i), bus.rsp_rdata, 32'hDEADBEEF);
            check($sformatf("full.busy_%0d", i), busy, 1'b0);
            step();
        end
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        check("full.req_ready_after_pop", bus.req_ready, 1'b1);
        check("full.head_after_pop", bus.rsp_rdata, 32'h11BB33DD);
        step();
        bus.req_valid = 1'b0;
        check("full.fifth_accepted", busy, 1'b1);
        step();
        pop_check("ord1", 1'b0, 1'b0, 32'h11BB33DD);
        pop_check("ord2", 1'b0, 1'b0, 32'h01020304);
        pop_check("ord3", 1'b0, 1'b0, 32'h55AA55AA);
        pop_check("ord4", 1'b0, 1'b1, 32'h0);
        check("ord.empty", bus.rsp_valid, 1'b0);

        // Reset during a write's wait states with two responses queued
        send(1'b0, 16'h0010, 32'h0, 4'h0, 4'd0);
        send(1'b0, 16'h0020, 32'h0, 4'h0, 4'd0);
        send(1'b1, 16'h0000, 32'hFFFFFFFF, 4'hF, 4'd5);
        check("mid.queued", bus.rsp_valid, 1'b1);
        check("mid.busy", busy, 1'b1);
        step();
        step();
        reset_n = 1'b0;
        #1;
        check("mid.rsp_valid", bus.rsp_valid, 1'b0);
        check("mid.busy_rst", busy, 1'b0);
        check("mid.req_ready_rst", bus.req_ready, 1'b0);
        check("mid.rsp_rdata", bus.rsp_rdata, 32'h0);
        step();
        step();
        reset_n = 1'b1;
        #1;
        check("mid.req_ready_rel", bus.req_ready, 1'b1);
        check("mid.rsp_valid_rel", bus.rsp_valid, 1'b0);
        step();
        send(1'b0, 16'h0000, 32'h0, 4'h0, 4'd0);
        pop_check("mid.r_prewrite", 1'b0, 1'b0, 32'h55AA55AA);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
